// File: rtl/rs_gbx_pkg.sv
// Shared gearbox definitions: staging-register state encoding and ratio/lane-width helpers.
package rs_gbx_pkg;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stg_state_t;

    function automatic int unsigned ratio_f(input int unsigned datasize, input int unsigned in_width);
        return datasize / in_width;
    endfunction

    // Lane index width, never narrower than one bit.
    function automatic int unsigned lane_w_f(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/rs_gbx_wr_packer_if.sv
// FIFO write-port bundle between the gearbox packer (master) and the async FIFO (slave).
interface rs_gbx_wr_packer_if #(
    parameter int unsigned DATASIZE = 32
);
    logic                fifo_wr;
    logic [DATASIZE-1:0] fifo_wr_data;
    logic                fifo_full;

    modport master (output fifo_wr, output fifo_wr_data, input fifo_full);
    modport slave  (input fifo_wr, input fifo_wr_data, output fifo_full);
endinterface

// File: rtl/rs_gbx_stage_reg.sv
// One-entry staging register in front of a FIFO write port; drops and flags words it cannot hold.
// RS_GBX_PACKER_OVF_CNT_EN enables the saturating dropped-word counter on ovf_cnt.
module rs_gbx_stage_reg
    import rs_gbx_pkg::*;
#(
    parameter int unsigned DATASIZE = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                wclk,
    input  logic                wr_reset_n,
    input  logic                offer,
    input  logic [DATASIZE-1:0] offer_data,
    input  logic                fifo_full,
    input  logic                ovf_clr,
    output logic                fifo_wr,
    output logic [DATASIZE-1:0] fifo_wr_data,
    output logic                overflow,
    output logic [CNT_W-1:0]    ovf_cnt
);

    stg_state_t          state_q, state_d;
    logic [DATASIZE-1:0] data_q;
    logic                push, load, drop;

    assign fifo_wr      = (state_q == STG_FULL);
    assign fifo_wr_data = data_q;
    assign push         = fifo_wr && !fifo_full;

    always_ff @(posedge wclk or negedge wr_reset_n) begin
        if (!wr_reset_n) state_q <= STG_EMPTY;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            STG_EMPTY: begin
                if (offer) begin
                    state_d = STG_FULL;
                    load    = 1'b1;
                end
            end
            STG_FULL: begin
                if (push) begin
                    if (offer) load    = 1'b1;
                    else       state_d = STG_EMPTY;
                end else if (offer) begin
                    drop = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wr_reset_n) begin
        if (!wr_reset_n)  data_q <= '0;
        else if (load)    data_q <= offer_data;
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge wclk or negedge wr_reset_n) begin
        if (!wr_reset_n)   overflow <= 1'b0;
        else if (drop)     overflow <= 1'b1;
        else if (ovf_clr)  overflow <= 1'b0;
    end

`ifdef RS_GBX_PACKER_OVF_CNT_EN
    always_ff @(posedge wclk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr)              ovf_cnt <= CNT_W'(1);
            else if (ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 1'b1;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: rtl/rs_gbx_wr_packer.sv
// Gearbox write-side packer: assembles IN_WIDTH beats into DATASIZE words for the async FIFO.
// RS_GBX_PACKER_OVF_CNT_EN enables the dropped-word counter (ovf_cnt reads 0 otherwise).
module rs_gbx_wr_packer
    import rs_gbx_pkg::*;
#(
    parameter int unsigned DATASIZE = 32,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                wclk,
    input  logic                wr_reset_n,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_sof,
    input  logic                flush,
    input  logic                ovf_clr,
    rs_gbx_wr_packer_if.master  fifo_if,
    output logic                overflow,
    output logic                frag_err,
    output logic [CNT_W-1:0]    ovf_cnt
);

    localparam int unsigned      RATIO     = ratio_f(DATASIZE, IN_WIDTH);
    localparam int unsigned      LANE_W    = lane_w_f(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if ((DATASIZE % IN_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
        $error("rs_gbx_wr_packer: DATASIZE must be a multiple of IN_WIDTH with a ratio of at least 2");
    end

    logic [LANE_W-1:0]   lane_q, lane_d, base_lane, lane_nxt;
    logic [DATASIZE-1:0] asm_q, asm_d, asm_w;
    logic                sof_beat, complete, offer, frag_d;

    // A start-of-frame beat restarts assembly from lane 0 before the beat is placed.
    always_comb begin
        sof_beat  = in_valid && in_sof;
        base_lane = sof_beat ? '0 : lane_q;
        asm_w     = sof_beat ? '0 : asm_q;
        lane_nxt  = lane_q;
        if (in_valid) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (base_lane == LANE_W'(i)) asm_w[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
            lane_nxt = base_lane + 1'b1;
        end
        complete = in_valid && (base_lane == LAST_LANE);
        offer    = complete || (flush && (lane_nxt != '0));
        frag_d   = sof_beat && (lane_q != '0);
        if (offer) begin
            lane_d = '0;
            asm_d  = '0;
        end else begin
            lane_d = lane_nxt;
            asm_d  = asm_w;
        end
    end

    always_ff @(posedge wclk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            lane_q   <= '0;
            asm_q    <= '0;
            frag_err <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            frag_err <= frag_d;
        end
    end

    rs_gbx_stage_reg #(
        .DATASIZE (DATASIZE),
        .CNT_W    (CNT_W)
    ) u_stage (
        .wclk         (wclk),
        .wr_reset_n   (wr_reset_n),
        .offer        (offer),
        .offer_data   (asm_w),
        .fifo_full    (fifo_if.fifo_full),
        .ovf_clr      (ovf_clr),
        .fifo_wr      (fifo_if.fifo_wr),
        .fifo_wr_data (fifo_if.fifo_wr_data),
        .overflow     (overflow),
        .ovf_cnt      (ovf_cnt)
    );

endmodule
